// File: rtl/branch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
//   Definitions shared by the branch redirect controller and by decode:
//   the redirect FSM state encoding, the RV32 control-flow opcodes, and a
//   small helper that flags a fetch target that is not word aligned.
// ---------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

  // Redirect sequencer states. Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } brc_state_t;

  // Control-flow opcodes (instr[6:0]); decode uses these to raise
  // ex_is_branch / ex_is_jump further up the pipe.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Byte distance to the sequential successor of an instruction.
  localparam int unsigned INSN_BYTES = 4;

  // A taken target whose low two bits are not zero cannot be fetched.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Free-running event counter that sticks at its all-ones value instead of
//   wrapping, so long perf runs never report a small bogus count.
//
//   Ports
//     clk    in  1  clock, rising edge
//     rst_n  in  1  asynchronous active-low reset, clears the count
//     inc    in  1  count one event this cycle
//     cnt    out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Increment only while below the ceiling; at all-ones the count freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   Resolves control flow in EX against the prediction fetch made. On a
//   mispredict it kills IF/ID and ID/EX in the detect cycle, then holds a
//   PC-redirect request to fetch (stalling EX) until fetch accepts it, and
//   finally drains DRAIN_CYCLES bubble cycles during which ID/EX keeps being
//   flushed and EX resolutions are treated as wrong-path. Misaligned taken
//   targets raise a one-cycle exception pulse instead of redirecting.
//   Resolved branches/jumps and mispredicts are counted for perf monitoring.
//
//   Parameters
//     XLEN          address width
//     DRAIN_CYCLES  bubble cycles after redirect accept (>= 1)
//     CNT_W         width of the saturating perf counters
//
//   Ports
//     clk             in   1      clock
//     rst_n           in   1      asynchronous active-low reset
//     ex_valid        in   1      EX holds a valid instruction
//     ex_is_branch    in   1      conditional branch in EX
//     ex_is_jump      in   1      jal/jalr in EX (always taken)
//     br_taken        in   1      branch condition result
//     ex_pred_taken   in   1      fetch's prediction for this instruction
//     ex_pc           in   XLEN   PC of the EX instruction
//     ex_target       in   XLEN   computed taken target
//     redirect_ready  in   1      fetch accepts the redirect
//     redirect_valid  out  1      redirect request to fetch
//     redirect_pc     out  XLEN   new fetch PC, stable while redirect_valid
//     flush_if_id     out  1      kill IF/ID contents
//     flush_id_ex     out  1      kill ID/EX contents
//     stall_ex        out  1      hold EX and upstream registers
//     misalign_exc    out  1      pulse: taken target not word aligned
//     branch_cnt      out  CNT_W  resolved branches + jumps (saturating)
//     mispred_cnt     out  CNT_W  mispredicts (saturating)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             br_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_ex,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // The drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  brc_state_t      state_q;
  brc_state_t      state_d;
  logic [DW-1:0]   drain_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            resolve;
  logic            actual_taken;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            mispred;
  logic            take_redirect;
  logic            handshake;

  // Resolution is only honoured in IDLE; anything seen in EX while a
  // redirect is outstanding or draining is on the wrong path. A jump wins
  // over a branch flag when decode raises both. The sequential PC wraps
  // silently at the top of the address space.
  assign resolve       = ex_valid & (ex_is_branch | ex_is_jump) & (state_q == IDLE);
  assign actual_taken  = ex_is_jump | br_taken;
  assign next_pc       = actual_taken ? ex_target : (ex_pc + XLEN'(INSN_BYTES));
  assign misalign      = resolve & actual_taken & is_misaligned(ex_target[1:0]);
  assign mispred       = resolve & (actual_taken != ex_pred_taken);
  assign take_redirect = mispred & ~misalign;
  assign handshake     = (state_q == REDIRECT) & redirect_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. REDIRECT has no timeout: fetch may hold off the
  // handshake for as long as it needs. The unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_redirect) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (handshake) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The detect-cycle flushes are combinational so the wrong
  // path instructions already in IF/ID and ID/EX die in that same cycle.
  always_comb begin
    redirect_valid = 1'b0;
    stall_ex       = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    misalign_exc   = 1'b0;
    case (state_q)
      IDLE: begin
        flush_if_id  = take_redirect;
        flush_id_ex  = take_redirect;
        misalign_exc = misalign;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        stall_ex       = 1'b1;
      end
      DRAIN: begin
        flush_id_ex = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The redirect target is captured once at detection and held untouched
  // until the next mispredict, so it stays stable across a long REDIRECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_q <= '0;
    end else if (take_redirect) begin
      redirect_pc_q <= next_pc;
    end
  end

  assign redirect_pc = redirect_pc_q;

  // Drain countdown: loaded on the accepting handshake, DRAIN leaves when it
  // reaches zero, giving exactly DRAIN_CYCLES cycles in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_q <= '0;
    end else if (handshake) begin
      drain_q <= DRAIN_LOAD;
    end else if ((state_q == DRAIN) && (drain_q != '0)) begin
      drain_q <= drain_q - DW'(1);
    end
  end

  // Misaligned taken targets still count as a resolved branch but never as
  // a mispredict, since no redirect is issued for them.
  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve),
    .cnt   (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take_redirect),
    .cnt   (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//   Drives directed and random EX resolutions into two controller instances
//   (16-bit and 2-bit perf counters) sharing one stimulus stream. A reference
//   model predicts each cycle's outputs and every redirect target; a monitor
//   on the opposite clock edge pops those predictions and compares.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int DRAIN = 2;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             br_taken;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_target;
  logic             redirect_ready;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             stall_ex;
  logic             misalign_exc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  logic             sat_redirect_valid;
  logic [XLEN-1:0]  sat_redirect_pc;
  logic             sat_flush_if_id;
  logic             sat_flush_id_ex;
  logic             sat_stall_ex;
  logic             sat_misalign_exc;
  logic [SAT_W-1:0] sat_branch_cnt;
  logic [SAT_W-1:0] sat_mispred_cnt;

  branch_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .br_taken(br_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_ex(stall_ex),
    .misalign_exc(misalign_exc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .br_taken(br_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .redirect_ready(redirect_ready),
    .redirect_valid(sat_redirect_valid), .redirect_pc(sat_redirect_pc),
    .flush_if_id(sat_flush_if_id), .flush_id_ex(sat_flush_id_ex), .stall_ex(sat_stall_ex),
    .misalign_exc(sat_misalign_exc), .branch_cnt(sat_branch_cnt), .mispred_cnt(sat_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit fif;
    bit fie;
    bit stall;
    bit rv;
    bit mis;
    int br;
    int mp;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] rq[$];
  exp_t        mon_e;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: a redirect is outstanding, and how many bubble
  // cycles are still owed after fetch accepted it.
  bit m_pending;
  int m_drain_left;
  int m_br;
  int m_mp;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint satv(input int v, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : longint'(v);
  endfunction

  // One clock of stimulus: drive the inputs, predict what the controller
  // must show this cycle, then advance the model to the next cycle.
  task automatic applyStimulus(input bit v, input bit br, input bit jmp, input bit tk,
                               input bit pr, input logic [31:0] pc,
                               input logic [31:0] tgt, input bit rdy);
    exp_t        e;
    bit          idle;
    bit          res;
    bit          act;
    bit          mis;
    bit          redir;
    logic [31:0] npc;
    @(posedge clk);
    #1;
    ex_valid       = v;
    ex_is_branch   = br;
    ex_is_jump     = jmp;
    br_taken       = tk;
    ex_pred_taken  = pr;
    ex_pc          = pc;
    ex_target      = tgt;
    redirect_ready = rdy;

    idle  = !m_pending && (m_drain_left == 0);
    res   = v && (br || jmp) && idle;
    act   = jmp || tk;
    npc   = act ? tgt : pc + 32'd4;
    mis   = res && act && (tgt[1:0] != 2'b00);
    redir = res && (act != pr) && !mis;

    e.fif   = redir;
    e.fie   = redir || (m_drain_left > 0);
    e.stall = m_pending;
    e.rv    = m_pending;
    e.mis   = mis;
    e.br    = m_br;
    e.mp    = m_mp;
    eq.push_back(e);

    if (res) m_br++;
    if (redir) begin
      m_mp++;
      m_pending = 1'b1;
      rq.push_back(npc);
    end else if (m_pending && rdy) begin
      m_pending    = 1'b0;
      m_drain_left = DRAIN;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; br_taken = 0;
    ex_pred_taken = 0; ex_pc = '0; ex_target = '0; redirect_ready = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_redirect_valid", redirect_valid, 0);
    checkOutput("rst_stall_ex", stall_ex, 0);
    checkOutput("rst_flush_id_ex", flush_id_ex, 0);
    checkOutput("rst_redirect_pc", redirect_pc, 0);
    checkOutput("rst_branch_cnt", branch_cnt, 0);
    checkOutput("rst_mispred_cnt", mispred_cnt, 0);
    eq.delete();
    rq.delete();
    m_pending    = 1'b0;
    m_drain_left = 0;
    m_br         = 0;
    m_mp         = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle out of reset pops the predicted outputs; while a
  // redirect is presented its PC must match the oldest expected target, and
  // the target retires on the accepting handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eq.size() > 0) begin
        mon_e = eq.pop_front();
        checkOutput("flush_if_id", flush_if_id, mon_e.fif);
        checkOutput("flush_id_ex", flush_id_ex, mon_e.fie);
        checkOutput("stall_ex", stall_ex, mon_e.stall);
        checkOutput("redirect_valid", redirect_valid, mon_e.rv);
        checkOutput("misalign_exc", misalign_exc, mon_e.mis);
        checkOutput("branch_cnt", branch_cnt, satv(mon_e.br, CNT_W));
        checkOutput("mispred_cnt", mispred_cnt, satv(mon_e.mp, CNT_W));
        checkOutput("sat_redirect_valid", sat_redirect_valid, mon_e.rv);
        checkOutput("sat_branch_cnt", sat_branch_cnt, satv(mon_e.br, SAT_W));
        checkOutput("sat_mispred_cnt", sat_mispred_cnt, satv(mon_e.mp, SAT_W));
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_redirect: got pc 0x%0h expected no redirect at %0t",
                   redirect_pc, $time);
        end else begin
          checkOutput("redirect_pc", redirect_pc, rq[0]);
          checkOutput("sat_redirect_pc", sat_redirect_pc, rq[0]);
          if (redirect_ready) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; br_taken = 0;
    ex_pred_taken = 0; ex_pc = '0; ex_target = '0; redirect_ready = 0;
    m_pending = 1'b0; m_drain_left = 0; m_br = 0; m_mp = 0;

    doReset();
    idleCycle(1'b0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);

    $display("[TB] BNE mispredict, taken, accepted at once");
    applyStimulus(1, 1, 0, 1, 0, 32'h100, 32'h180, 0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("bne_redirect_pc", redirect_pc, 32'h180);
    checkOutput("bne_mispred_cnt", mispred_cnt, 1);

    $display("[TB] BEQ mispredict, not taken, fetch holds off");
    applyStimulus(1, 1, 0, 0, 1, 32'h200, 32'h300, 1);
    repeat (5) idleCycle(1'b0);
    checkOutput("beq_stall_held", stall_ex, 1);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h204);

    $display("[TB] JAL predicted, JALR misaligned");
    applyStimulus(1, 0, 1, 0, 1, 32'h300, 32'h400, 0);
    applyStimulus(1, 0, 1, 1, 1, 32'h404, 32'h402, 0);
    idleCycle(1'b0);
    checkOutput("jal_branch_cnt", branch_cnt, 4);
    checkOutput("jal_mispred_cnt", mispred_cnt, 2);

    $display("[TB] Resolutions during REDIRECT and DRAIN");
    applyStimulus(1, 1, 0, 1, 0, 32'h500, 32'h580, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h600, 32'h700, 0);
    applyStimulus(1, 0, 1, 0, 0, 32'h600, 32'h700, 1);
    applyStimulus(1, 1, 0, 1, 0, 32'h800, 32'h900, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h800, 32'h900, 0);
    idleCycle(1'b0);
    checkOutput("wrongpath_redirect_pc", redirect_pc, 32'h580);
    checkOutput("wrongpath_branch_cnt", branch_cnt, 5);
    checkOutput("wrongpath_mispred_cnt", mispred_cnt, 3);

    $display("[TB] Sequential PC wraps");
    applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h1000, 0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("wrap_redirect_pc", redirect_pc, 32'h0);

    $display("[TB] Reset while REDIRECT outstanding");
    applyStimulus(1, 1, 0, 1, 0, 32'h100, 32'h180, 0);
    idleCycle(1'b0);
    doReset();

    $display("[TB] Counter saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 0);
      idleCycle(1'b1);
      idleCycle(1'b0);
      idleCycle(1'b0);
    end
    checkOutput("sat_mispred_cnt_final", sat_mispred_cnt, 3);
    checkOutput("full_mispred_cnt_final", mispred_cnt, 5);

    $display("[TB] Random stimulus");
    for (int i = 0; i < 3000; i++) begin
      bit          v;
      bit          br;
      bit          jmp;
      int          kind;
      logic [31:0] pc;
      logic [31:0] tgt;
      v    = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 4);
      br   = (kind == 1) || (kind == 2) || (kind == 4);
      jmp  = (kind >= 3);
      pc   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      tgt  = $urandom;
      if ($urandom_range(0, 7) != 0) tgt = tgt & 32'hFFFF_FFFC;
      applyStimulus(v, br, jmp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    pc, tgt, 1'($urandom_range(0, 1)));
    end

    repeat (8) idleCycle(1'b1);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", eq.size(), 0);
    checkOutput("redirects_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
